// File: rtl/wbc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wbc_rr_arbiter
// Round-robin arbiter for the control WISHBONE bus. NM masters (0 = PCI,
// 1 = TURF, 2 = HK) share one slave-side port that feeds the shared-bus
// decoder. A master keeps the grant for its whole cyc tenure, so locked
// multi-access sequences are never split. A watchdog ends a stalled strobe
// with an error while the grant is kept.
//
// Ports
//   clk_i, rst_n_i            control bus clock, async active-low reset
//   m_cyc_i/stb_i/we_i        per-master cycle, strobe, write enable
//   m_adr_i/dat_i/sel_i       per-master address/data/selects, master k in
//                             slice [k*W +: W]
//   m_ack_o/err_o/rty_o       responses, only the granted master's bit set
//   m_dat_o                   read data broadcast to all masters
//   s_cyc_o .. s_sel_o        slave-side request, muxed from the grant
//   s_ack_i/err_i/rty_i/dat_i slave responses and read data
//   grant_o                   one-hot registered grant (zero when idle)
//   timeout_o                 one-cycle pulse when the watchdog fires
//   state_o                   FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a transfer is requested while cyc and stb are both high and
// completes in the cycle the slave returns ack, err or rty while stb is high.
// Responses seen while stb is low are ignored. cyc framing alone owns the
// grant: dropping cyc ends the tenure in that same cycle.
// -----------------------------------------------------------------------------
module wbc_rr_arbiter #(
  parameter int NM      = 3,
  parameter int AW      = 20,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [NM-1:0]        m_rty_o,
  output logic [DW-1:0]        m_dat_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic                 s_rty_i,
  input  logic [DW-1:0]        s_dat_i,
  output logic [NM-1:0]        grant_o,
  output logic                 timeout_o,
  output logic                 state_o
);

  localparam int SW = DW / 8;
  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  // Counter value seen in the stalled cycle that is the TIMEOUT-th one.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NM-1:0]   grant_q, grant_d;
  logic [GW-1:0]   gidx_q, gidx_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [15:0]     wd_q, wd_d;

  logic            busy;
  logic            cyc_g;
  logic            stb_raw;
  logic            resp;
  logic            stalled;
  logic            wd_fire;
  logic            found;
  int              sel_idx;

  assign busy    = (state_q == BUSY);
  assign cyc_g   = m_cyc_i[gidx_q];
  assign stb_raw = busy & cyc_g & m_stb_i[gidx_q];
  assign resp    = s_ack_i | s_err_i | s_rty_i;
  assign stalled = stb_raw & ~resp;
  // Any response in the terminal cycle masks the watchdog, so ack wins.
  assign wd_fire = stalled & (wd_q == WD_LAST);

  // Slave-side request, muxed from the granted master.
  assign s_cyc_o = busy & cyc_g;
  assign s_stb_o = stb_raw & ~wd_fire;
  assign s_we_o  = busy & m_we_i[gidx_q];
  assign s_adr_o = busy ? m_adr_i[gidx_q*AW +: AW] : '0;
  assign s_dat_o = busy ? m_dat_i[gidx_q*DW +: DW] : '0;
  assign s_sel_o = busy ? m_sel_i[gidx_q*SW +: SW] : '0;

  // Responses gated with the raw strobe: late responses after cyc/stb drop
  // never reach a master. grant_q is zero outside BUSY.
  assign m_ack_o   = (stb_raw & s_ack_i) ? grant_q : '0;
  assign m_err_o   = ((stb_raw & s_err_i) | wd_fire) ? grant_q : '0;
  assign m_rty_o   = (stb_raw & s_rty_i) ? grant_q : '0;
  assign m_dat_o   = s_dat_i;
  assign timeout_o = wd_fire;
  assign grant_o   = grant_q;
  assign state_o   = busy;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wd_d    = '0;
    found   = 1'b0;
    sel_idx = 0;
    case (state_q)
      IDLE: begin
        // First requester at or after the pointer, wrapping modulo NM.
        for (int i = 0; i < NM; i++) begin
          sel_idx = (int'(ptr_q) + i) % NM;
          if (!found && m_cyc_i[sel_idx]) begin
            found            = 1'b1;
            gidx_d           = GW'(sel_idx);
            grant_d          = '0;
            grant_d[sel_idx] = 1'b1;
            state_d          = BUSY;
          end
        end
      end
      BUSY: begin
        if (!cyc_g) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (int'(gidx_q) == NM - 1) ? '0 : GW'(gidx_q + 1'b1);
        end else if (stalled && !wd_fire) begin
          wd_d = wd_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_wbc_rr_arbiter.sv
module tb_wbc_rr_arbiter;

  localparam int NM  = 3;
  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;
  localparam int EW  = 3 + 1 + 1 + 3 + 3 + 3 + 1 + 1 + AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NM-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]   m_adr_i;
  logic [NM*DW-1:0]   m_dat_i;
  logic [NM*SW-1:0]   m_sel_i;
  logic [NM-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic [DW-1:0]      m_dat_o;
  logic               s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]      s_adr_o;
  logic [DW-1:0]      s_dat_o;
  logic [SW-1:0]      s_sel_o;
  logic               s_ack_i, s_err_i, s_rty_i;
  logic [DW-1:0]      s_dat_i;
  logic [NM-1:0]      grant_o;
  logic               timeout_o;
  logic               state_o;

  wbc_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o), .state_o(state_o)
  );

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [2:0] cyc;
    logic [2:0] stb;
    logic       ack, err, rty;
    logic [2:0] grant;
    logic       scyc, sstb;
    logic [2:0] mack, merr, mrty;
    logic       tmo;
  } vec_t;

  function automatic vec_t v(input logic [2:0] cyc, input logic [2:0] stb,
                             input logic ack, input logic err, input logic rty,
                             input logic [2:0] grant, input logic scyc, input logic sstb,
                             input logic [2:0] mack, input logic [2:0] merr,
                             input logic [2:0] mrty, input logic tmo);
    vec_t t;
    t.cyc = cyc; t.stb = stb; t.ack = ack; t.err = err; t.rty = rty;
    t.grant = grant; t.scyc = scyc; t.sstb = sstb;
    t.mack = mack; t.merr = merr; t.mrty = mrty; t.tmo = tmo;
    return t;
  endfunction

  logic [AW-1:0] mst_adr [NM];
  logic [DW-1:0] mst_dat [NM];
  vec_t          tbl [$];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q [$];
  int tests_run = 0;
  int fail_cnt  = 0;

  function automatic logic [EW-1:0] pack(input vec_t t);
    logic [AW-1:0] adr;
    adr = '0;
    for (int k = 0; k < NM; k++) if (t.grant[k]) adr = mst_adr[k];
    return {t.grant, t.scyc, t.sstb, t.mack, t.merr, t.mrty, t.tmo, |t.grant, adr};
  endfunction

  task automatic check(input string name);
    logic [EW-1:0] exp_v, act_v;
    logic [2:0]    exp_g;
    tests_run++;
    if (exp_q.size() == 0) begin
      fail_cnt++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      exp_v = exp_q.pop_front();
      exp_g = exp_v[EW-1 -: 3];
      act_v = {grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, timeout_o, state_o,
               (exp_g == 3'b000) ? {AW{1'b0}} : s_adr_o};
      if (act_v !== exp_v) begin
        fail_cnt++;
        $display("FAIL %s: got %h expected %h (grant,cyc,stb,ack,err,rty,tmo,busy,adr)",
                 name, act_v, exp_v);
      end
    end
  endtask

  task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string name, input vec_t t);
    @(posedge clk);
    #1;
    m_cyc_i = t.cyc; m_stb_i = t.stb;
    s_ack_i = t.ack; s_err_i = t.err; s_rty_i = t.rty;
    exp_q.push_back(pack(t));
    @(negedge clk);
    check(name);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = 3'b010;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    s_dat_i = 32'hDEADBEEF;
    for (int k = 0; k < NM; k++) begin
      mst_adr[k] = {2'(k), 18'($urandom_range(0, 262143))};
      mst_dat[k] = $urandom_range(0, 32'hFFFF_FFFF);
      m_adr_i[k*AW +: AW] = mst_adr[k];
      m_dat_i[k*DW +: DW] = mst_dat[k];
      m_sel_i[k*SW +: SW] = 4'($urandom_range(1, 15));
    end

    // Reset state
    #12;
    exp_q.push_back(pack(v(0,0,0,0,0, 0,0,0, 0,0,0,0)));
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // cyc stb ack err rty | grant scyc sstb mack merr mrty tmo
    // rotation across all three masters with the IDLE gap
    tbl.push_back(v(3'b000,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b111,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b111,3'b001,0,0,0, 3'b001,1,1, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b111,3'b001,1,0,0, 3'b001,1,1, 3'b001,3'b000,3'b000,0));
    tbl.push_back(v(3'b110,3'b000,0,0,0, 3'b001,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b110,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b110,3'b010,0,0,0, 3'b010,1,1, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b110,3'b010,1,0,0, 3'b010,1,1, 3'b010,3'b000,3'b000,0));
    tbl.push_back(v(3'b100,3'b000,0,0,0, 3'b010,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b101,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b101,3'b100,0,0,0, 3'b100,1,1, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b101,3'b100,1,0,0, 3'b100,1,1, 3'b100,3'b000,3'b000,0));
    tbl.push_back(v(3'b001,3'b000,0,0,0, 3'b100,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b001,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b001,3'b001,0,0,0, 3'b001,1,1, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b001,3'b001,1,0,0, 3'b001,1,1, 3'b001,3'b000,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,0,0,0, 3'b001,0,0, 3'b000,3'b000,3'b000,0));
    // master 1 locks the bus for 4 acks while master 0 waits
    tbl.push_back(v(3'b011,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b011,3'b010,1,0,0, 3'b010,1,1, 3'b010,3'b000,3'b000,0));
    tbl.push_back(v(3'b011,3'b010,1,0,0, 3'b010,1,1, 3'b010,3'b000,3'b000,0));
    tbl.push_back(v(3'b011,3'b000,0,0,0, 3'b010,1,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b011,3'b010,1,0,0, 3'b010,1,1, 3'b010,3'b000,3'b000,0));
    tbl.push_back(v(3'b011,3'b010,1,0,0, 3'b010,1,1, 3'b010,3'b000,3'b000,0));
    tbl.push_back(v(3'b001,3'b000,0,0,0, 3'b010,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b001,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    // multi-response passthrough, response with stb low, late ack after cyc drop
    tbl.push_back(v(3'b001,3'b001,0,1,1, 3'b001,1,1, 3'b000,3'b001,3'b001,0));
    tbl.push_back(v(3'b001,3'b000,1,0,0, 3'b001,1,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b011,3'b001,1,1,0, 3'b001,1,1, 3'b001,3'b001,3'b000,0));
    tbl.push_back(v(3'b010,3'b010,1,0,0, 3'b001,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b010,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,0,0,0, 3'b010,0,0, 3'b000,3'b000,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // Watchdog: master 1 (pointer now 2), slave silent for TMO cycles
    step("wd_idle", v(3'b010,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    for (int c = 1; c <= TMO; c++) begin
      step($sformatf("wd_stall%0d", c),
           v(3'b010,3'b010,0,0,0, 3'b010,1,(c != TMO),
             3'b000,(c == TMO) ? 3'b010 : 3'b000,3'b000,(c == TMO)));
      if (c == 1) begin
        chk32("wd_s_dat", s_dat_o, mst_dat[1]);
        chk32("wd_s_we", {31'd0, s_we_o}, 32'd1);
      end
    end
    // Ack lands exactly on the next terminal count: ack wins
    for (int c = 1; c <= TMO; c++) begin
      step($sformatf("wd_ack%0d", c),
           v(3'b010,3'b010,(c == TMO),0,0, 3'b010,1,1,
             (c == TMO) ? 3'b010 : 3'b000,3'b000,3'b000,0));
      if (c == TMO) chk32("wd_ack_rdata", m_dat_o, 32'hDEADBEEF);
    end
    step("wd_after_ack", v(3'b010,3'b010,0,0,0, 3'b010,1,1, 3'b000,3'b000,3'b000,0));
    step("wd_release",   v(3'b000,3'b000,0,0,0, 3'b010,0,0, 3'b000,3'b000,3'b000,0));
    step("wd_idle_gap",  v(3'b000,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));

    // Asynchronous reset mid-access with grant 010 (pointer is 2)
    step("rst_req",  v(3'b010,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    step("rst_busy", v(3'b010,3'b010,0,0,0, 3'b010,1,1, 3'b000,3'b000,3'b000,0));
    @(posedge clk);
    #1;
    s_ack_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(pack(v(0,0,0,0,0, 0,0,0, 0,0,0,0)));
    check("async_reset");
    m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Pointer restarts at 0: master 0 wins over 1 and 2
    step("post_rst_req",  v(3'b111,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));
    step("post_rst_gnt",  v(3'b111,3'b001,1,0,0, 3'b001,1,1, 3'b001,3'b000,3'b000,0));
    step("post_rst_rel",  v(3'b000,3'b000,0,0,0, 3'b001,0,0, 3'b000,3'b000,3'b000,0));
    step("post_rst_idle", v(3'b000,3'b000,0,0,0, 3'b000,0,0, 3'b000,3'b000,3'b000,0));

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
